// File: rtl/sbox_ctrl_pkg.sv
// sbox_ctrl_pkg: shared widths, FSM encoding and LFSR constants
// for the masked S-box randomness controller.
package sbox_ctrl_pkg;

  localparam int STATIC_W = 139;
  localparam int DYN_W    = 64;
  localparam int GUARD_W  = 32;
  localparam int ROUND_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // taps at bits 63, 62, 60, 59
  localparam logic [DYN_W-1:0] LFSR_TAPS =
    64'hD800_0000_0000_0000;

  // an all-zero seed would lock the LFSR
  localparam logic [DYN_W-1:0] LFSR_ZERO_SUB =
    64'h0000_0000_0000_0001;

  function automatic logic [DYN_W-1:0] lfsr_next(
    input logic [DYN_W-1:0] s
  );
    return {s[DYN_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr64.sv
// lfsr64: 64-bit Fibonacci LFSR with seed load and step enable.
// Ports: clk, rst, load, step, seed[63:0] -> state[63:0].
module lfsr64
  import sbox_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [DYN_W-1:0] seed,
  output logic [DYN_W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/sbox_rand_ctrl.sv
// sbox_rand_ctrl: randomness/guard driver and round sequencer for
// the 3-share masked S-box layer.
// Ports: clk, rst, start, static_in, guards_in, seed_in ->
//   Static_r, Dynamic_r, Guards, Guards_MUX_sel, sbox_in_valid,
//   sbox_out_valid, round_idx, busy, done.
// Option: STATIC_REFRESH_EN xors the old LFSR state into Static_r.
module sbox_rand_ctrl
  import sbox_ctrl_pkg::*;
#(
  parameter int SBOX_LAT     = 4,
  parameter int ROUND_PERIOD = 5,
  parameter int NUM_ROUNDS   = 10,
  parameter int GUARD_DEPTH  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STATIC_W-1:0] static_in,
  input  logic [GUARD_W-1:0]  guards_in,
  input  logic [DYN_W-1:0]    seed_in,
  output logic [STATIC_W-1:0] Static_r,
  output logic [DYN_W-1:0]    Dynamic_r,
  output logic [GUARD_W-1:0]  Guards,
  output logic                Guards_MUX_sel,
  output logic                sbox_in_valid,
  output logic                sbox_out_valid,
  output logic [ROUND_W-1:0]  round_idx,
  output logic                busy,
  output logic                done
);

  localparam int PH_W =
    (ROUND_PERIOD > 1) ? $clog2(ROUND_PERIOD) : 1;
  localparam int GC_W = $clog2(GUARD_DEPTH + 2);
  localparam logic [SBOX_LAT-1:0] PIPE_HEAD =
    SBOX_LAT'(1) << (SBOX_LAT - 1);

  state_t              st;
  logic [PH_W-1:0]     phase;
  logic [GC_W-1:0]     gcnt;
  logic [SBOX_LAT-1:0] vpipe;
  logic [DYN_W-1:0]    dyn;
  logic                accept;
  logic                in_run;
  logic                stepping;
  logic                issue;
  logic                last_out;

  assign accept   = (st == S_IDLE) && start;
  assign in_run   = (st == S_RUN);
  assign stepping = in_run || (st == S_DRAIN);
  assign issue    = in_run && (phase == '0) &&
                    (round_idx < ROUND_W'(NUM_ROUNDS));
  // nothing behind the pipe head: this cycle holds the final result
  assign last_out = (vpipe & ~PIPE_HEAD) == '0;

  lfsr64 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (stepping),
    .seed  (seed_in),
    .state (dyn)
  );

  assign Dynamic_r      = dyn;
  assign sbox_in_valid  = issue;
  assign sbox_out_valid = vpipe[SBOX_LAT-1];
  assign Guards_MUX_sel = in_run &&
                          (gcnt < GC_W'(GUARD_DEPTH));
  assign busy           = stepping;
  assign done           = (st == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      phase     <= '0;
      gcnt      <= '0;
      vpipe     <= '0;
      round_idx <= '0;
      Static_r  <= '0;
      Guards    <= '0;
    end else begin
      vpipe <= (vpipe << 1) | SBOX_LAT'(issue);
      unique case (st)
        S_IDLE: begin
          if (start) begin
`ifdef STATIC_REFRESH_EN
            Static_r <= static_in ^
                        {dyn[10:0], dyn, dyn};
`else
            Static_r <= static_in;
`endif
            Guards    <= guards_in;
            phase     <= '0;
            gcnt      <= '0;
            round_idx <= '0;
            st        <= S_RUN;
          end
        end
        S_RUN: begin
          if (round_idx == ROUND_W'(NUM_ROUNDS)) begin
            st <= S_DRAIN;
          end else begin
            phase <= (phase == PH_W'(ROUND_PERIOD - 1)) ?
                     '0 : phase + 1'b1;
            if (issue) begin
              round_idx <= round_idx + 1'b1;
            end
            if (gcnt < GC_W'(GUARD_DEPTH)) begin
              gcnt <= gcnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (last_out) begin
            st <= S_DONE;
          end
        end
        S_DONE: begin
          round_idx <= '0;
          st        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_rand_ctrl.sv
// tb_sbox_rand_ctrl: directed stimulus, per-cycle reference model
// compare and literal schedule checks for sbox_rand_ctrl.
module tb_sbox_rand_ctrl;

  localparam int L  = 4;
  localparam int P  = 5;
  localparam int N  = 10;
  localparam int G  = 10;
  localparam int LAST_IN  = (N - 1) * P;
  localparam int RUN_LAST = LAST_IN + 1;
  localparam int DONE_K =
    ((LAST_IN + L > RUN_LAST) ? LAST_IN + L : RUN_LAST) + 1;

  localparam logic [138:0] SA =
    {11'h5A5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
  localparam logic [138:0] SB =
    {11'h0F0, 64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444};
  localparam logic [138:0] SC =
    {11'h7FF, 64'h0000_FFFF_0000_FFFF, 64'h8000_0000_0000_0001};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [138:0] static_in = '0;
  logic [31:0]  guards_in = '0;
  logic [63:0]  seed_in = '0;
  logic [138:0] Static_r;
  logic [63:0]  Dynamic_r;
  logic [31:0]  Guards;
  logic         Guards_MUX_sel;
  logic         sbox_in_valid;
  logic         sbox_out_valid;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  sbox_rand_ctrl #(
    .SBOX_LAT     (L),
    .ROUND_PERIOD (P),
    .NUM_ROUNDS   (N),
    .GUARD_DEPTH  (G)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .static_in      (static_in),
    .guards_in      (guards_in),
    .seed_in        (seed_in),
    .Static_r       (Static_r),
    .Dynamic_r      (Dynamic_r),
    .Guards         (Guards),
    .Guards_MUX_sel (Guards_MUX_sel),
    .sbox_in_valid  (sbox_in_valid),
    .sbox_out_valid (sbox_out_valid),
    .round_idx      (round_idx),
    .busy           (busy),
    .done           (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [138:0] act,
                     logic [138:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lstep(logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // model: encryption timeline indexed by cycles since accept
  bit           m_active = 1'b0;
  int           m_k = 0;
  logic [63:0]  m_dyn = '0;
  logic [138:0] m_static = '0;
  logic [31:0]  m_guards = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_dyn    <= '0;
      m_static <= '0;
      m_guards <= '0;
    end else if (m_active) begin
      if (m_k < DONE_K) m_dyn <= lstep(m_dyn);
      if (m_k == DONE_K) m_active <= 1'b0;
      else m_k <= m_k + 1;
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_dyn    <= (seed_in == '0) ? 64'h1 : seed_in;
      m_guards <= guards_in;
`ifdef STATIC_REFRESH_EN
      m_static <= static_in ^ {m_dyn[10:0], m_dyn, m_dyn};
`else
      m_static <= static_in;
`endif
    end
  end

  always @(negedge clk) begin
    bit e_iv, e_ov, e_sel, e_bz, e_dn;
    int e_ri;
    e_iv = 0; e_ov = 0; e_sel = 0;
    e_bz = 0; e_dn = 0; e_ri = 0;
    if (!rst) begin
      if (m_active) begin
        e_iv = (m_k <= LAST_IN) && (m_k % P == 0);
        e_ov = (m_k >= L) && (m_k - L <= LAST_IN) &&
               ((m_k - L) % P == 0);
        e_ri = (m_k + P - 1) / P;
        if (e_ri > N) e_ri = N;
        e_sel = (m_k < G) && (m_k <= RUN_LAST);
        e_bz  = m_k < DONE_K;
        e_dn  = m_k == DONE_K;
      end
      chk("in_valid", sbox_in_valid, e_iv);
      chk("out_valid", sbox_out_valid, e_ov);
      chk("round_idx", round_idx, e_ri);
      chk("mux_sel", Guards_MUX_sel, e_sel);
      chk("busy", busy, e_bz);
      chk("done", done, e_dn);
      chk("Dynamic_r", Dynamic_r, m_dyn);
      chk("Static_r", Static_r, m_static);
      chk("Guards", Guards, m_guards);
      if (m_active) chk("dyn_nonzero", Dynamic_r != '0, 1'b1);
    end
  end

  // observed schedule, indexed by model cycle
  int          qin[$];
  int          qout[$];
  int          qsel[$];
  int          done_k = -1;
  int          ridx_done = -1;
  logic [63:0] dyn_k0, dyn_k1, dyn_k2;

  always @(negedge clk) begin
    if (!rst && m_active) begin
      if (sbox_in_valid) qin.push_back(m_k);
      if (sbox_out_valid) qout.push_back(m_k);
      if (Guards_MUX_sel) qsel.push_back(m_k);
      if (m_k == 0) dyn_k0 = Dynamic_r;
      if (m_k == 1) dyn_k1 = Dynamic_r;
      if (m_k == 2) dyn_k2 = Dynamic_r;
      if (done) begin
        done_k = m_k;
        ridx_done = int'(round_idx);
      end
    end
  end

  task automatic clr_rec();
    qin.delete();
    qout.delete();
    qsel.delete();
    done_k = -1;
    ridx_done = -1;
  endtask

  task automatic go(logic [63:0] sd, logic [138:0] st,
                    logic [31:0] gd);
    @(negedge clk);
    clr_rec();
    seed_in = sd;
    static_in = st;
    guards_in = gd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_k(string nm, int k);
    int n = 0;
    while (!(m_active && m_k == k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(m_active && m_k == k)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: cycle %0d never reached", nm, k);
    end
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (m_active && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (m_active) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for idle", nm);
    end
  endtask

  task automatic check_sched(string t);
    chk({t, "_in_cnt"}, qin.size(), 10);
    for (int i = 0; i < qin.size() && i < 10; i++)
      chk({t, "_in_cyc"}, qin[i], 5 * i);
    chk({t, "_out_cnt"}, qout.size(), 10);
    for (int i = 0; i < qout.size() && i < 10; i++)
      chk({t, "_out_cyc"}, qout[i], 5 * i + 4);
    chk({t, "_done_cyc"}, done_k, 50);
    chk({t, "_rounds"}, ridx_done, 10);
    chk({t, "_sel_cnt"}, qsel.size(), 10);
    if (qsel.size() > 0) begin
      chk({t, "_sel_first"}, qsel[0], 0);
      chk({t, "_sel_last"}, qsel[qsel.size()-1], 9);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_round_idx", round_idx, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sel", Guards_MUX_sel, 1'b0);
    chk("rst_in_valid", sbox_in_valid, 1'b0);
    chk("rst_out_valid", sbox_out_valid, 1'b0);
    chk("rst_dyn", Dynamic_r, 64'h0);
    chk("rst_static", Static_r, 139'h0);
    chk("rst_guards", Guards, 32'h0);
    rst = 1'b0;

    // A: seed 1, start retried mid-run with new static_in
    go(64'h1, SA, 32'hDEADBEEF);
    wait_k("A_mid", 20);
    static_in = SB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("A");
    check_sched("A");
    chk("A_dyn_k1", dyn_k1, 64'h2);
    chk("A_static", Static_r, SA);
    chk("A_guards", Guards, 32'hDEADBEEF);
    chk("A_idle_round", round_idx, 4'd0);

    // B: zero seed; start held through DONE launches C
    go(64'h0, SB, 32'hCAFEF00D);
    wait_k("B_end", 48);
    seed_in = 64'hC000_0000_0000_0000;
    static_in = SC;
    guards_in = 32'h0BAD_F00D;
    start = 1'b1;
    wait_idle("B");
    chk("B_dyn_k0", dyn_k0, 64'h1);
    chk("B_done_cyc", done_k, 50);
    clr_rec();
    @(negedge clk);
    start = 1'b0;
    chk("C_busy", busy, 1'b1);
    wait_idle("C");
    check_sched("C");
    chk("C_dyn_k1", dyn_k1, 64'h8000_0000_0000_0000);
    chk("C_dyn_k2", dyn_k2, 64'h1);
    chk("C_guards", Guards, 32'h0BAD_F00D);

    // D: asynchronous reset in the middle of an encryption
    go(64'h1357_9BDF_2468_ACE0, SC, 32'h5555_AAAA);
    wait_k("D_mid", 17);
    #2 rst = 1'b1;
    #1;
    chk("D_rst_busy", busy, 1'b0);
    chk("D_rst_round", round_idx, 4'd0);
    chk("D_rst_sel", Guards_MUX_sel, 1'b0);
    chk("D_rst_in_valid", sbox_in_valid, 1'b0);
    chk("D_rst_out_valid", sbox_out_valid, 1'b0);
    chk("D_rst_dyn", Dynamic_r, 64'h0);
    chk("D_rst_static", Static_r, 139'h0);
    chk("D_rst_guards", Guards, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // E: full fresh encryption after the reset
    go(64'h1, SA ^ SB, 32'h1234_5678);
    wait_idle("E");
    check_sched("E");
    chk("E_dyn_k1", dyn_k1, 64'h2);
    chk("E_static", Static_r, SA ^ SB);
    chk("E_guards", Guards, 32'h1234_5678);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
